// File: rtl/cdc_xfer_pkg.sv
// Shared types and constants for the toggle-handshake transfer arbiter.
// The optional timeout feature is enabled by defining CDC_XFER_TIMEOUT_EN.
package cdc_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr_i,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_valid;
  logic [ID_W-1:0]    hi_idx;
  logic [ID_W-1:0]    lo_idx;
  logic               hi_any;
  logic               lo_any;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign hi_mask[gi] = (ID_W'(gi) >= ptr_i);
  end

  assign hi_valid = valid_i & hi_mask;

  // Requests at or above the pointer win; otherwise wrap to the lowest one.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hi_valid[k]) begin
        hi_idx = ID_W'(k);
        hi_any = 1'b1;
      end
      if (valid_i[k]) begin
        lo_idx = ID_W'(k);
        lo_any = 1'b1;
      end
    end
  end

  assign idx_o = hi_any ? hi_idx : lo_idx;
  assign any_o = lo_any;

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_o[gi] = any_o && (idx_o == ID_W'(gi));
  end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin sharing of one toggle-handshake crossing among NUM_REQ requesters.
// Define CDC_XFER_TIMEOUT_EN to add the WAIT_ACK timeout and sticky ERR state.
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]           xfer_data_o,
  output logic                        xfer_tog_o,
  input  logic                        xfer_ack_tog_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(NUM_REQ)-1:0]  done_id_o,
  output logic                        err_timeout_o
);

  localparam int ID_W = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 ||
      DATA_W < 1) begin : g_param_check
    $error("cdc_xfer_arbiter: parameter out of range");
  end

  state_t               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      ptr_d;
  logic [DATA_W-1:0]    data_q;
  logic                 tog_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ID_W-1:0]      done_id_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                 ack_s;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [DATA_W-1:0]    words [NUM_REQ];
  logic [DATA_W-1:0]    win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  assign win_data = words[arb_idx];
  assign ptr_d    = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // The raw ack toggle is asynchronous; only its synchronised copy is used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_tog_i};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

`ifdef CDC_XFER_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      data_q     <= '0;
      tog_q      <= 1'b0;
      ready_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
`ifdef CDC_XFER_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            data_q     <= win_data;
            tog_q      <= ~tog_q;
            ready_q    <= arb_grant;
            ptr_q      <= ptr_d;
            done_id_q  <= arb_idx;
            busy_q     <= 1'b1;
            state_q    <= WAIT_ACK;
`ifdef CDC_XFER_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (ack_s == tog_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef CDC_XFER_TIMEOUT_EN
          end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef CDC_XFER_TIMEOUT_EN
        ERR: begin
          state_q <= ERR;
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign xfer_data_o = data_q;
  assign xfer_tog_o  = tog_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;

`ifdef CDC_XFER_TIMEOUT_EN
  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Scoreboard bench for cdc_xfer_arbiter with a behavioural destination echo.
// Define CDC_XFER_TIMEOUT_EN to exercise the timeout/ERR path instead of the wait-forever path.
module tb_cdc_xfer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int SYNC_ST = 2;
  localparam int TMO     = 16;
  localparam int ECHO    = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         xfer_data_o;
  logic                      xfer_tog_o;
  logic                      xfer_ack_tog;
  logic                      busy_o;
  logic                      done_o;
  logic [1:0]                done_id_o;
  logic                      err_timeout_o;

  always #5 clk = ~clk;

  cdc_xfer_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .SYNC_STAGES    (SYNC_ST),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready_o),
    .xfer_data_o    (xfer_data_o),
    .xfer_tog_o     (xfer_tog_o),
    .xfer_ack_tog_i (xfer_ack_tog),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .done_id_o      (done_id_o),
    .err_timeout_o  (err_timeout_o)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [NUM_REQ-1:0] sticky;
  int   rdy_cnt [NUM_REQ];
  int   rdy_total = 0;
  int   done_cnt  = 0;
  int   tog_cnt   = 0;
  int   last_id   = 0;
  logic prev_tog  = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic echo_en;
  logic dest_rst;
  bit   pend = 1'b0;
  int   ecnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    req_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.id   = i;
    e.data = req_data[i*DATA_W +: DATA_W];
    sb_q.push_back(e);
  endtask

  // One cycle: sample at the falling edge, score, then drive requester and destination.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (req_ready_o != '0) begin
      check("ready_from_idle", 64'(prev_busy), 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'(req_ready_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ready_onehot", 64'(req_ready_o), 64'd1 << e.id);
        check("xfer_data", 64'(xfer_data_o), 64'(e.data));
        last_id = e.id;
      end
      $display("grant ready=%b data=0x%08h tog=%0b", req_ready_o, xfer_data_o, xfer_tog_o);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i]) begin
          rdy_cnt[i]++;
          rdy_total++;
          if (!sticky[i]) req_valid[i] = 1'b0;
        end
      end
    end
    if (done_o) begin
      done_cnt++;
      check("done_single", 64'(prev_done), 64'd0);
      check("done_id", 64'(done_id_o), 64'(last_id));
      $display("done id=%0d", done_id_o);
    end
    if (xfer_tog_o !== prev_tog) tog_cnt++;
    prev_tog  = xfer_tog_o;
    prev_busy = busy_o;
    prev_done = done_o;
    if (dest_rst) begin
      xfer_ack_tog = 1'b0;
      pend = 1'b0;
    end else if (pend) begin
      ecnt--;
      if (ecnt == 0) begin
        xfer_ack_tog = xfer_tog_o;
        pend = 1'b0;
      end
    end else if (echo_en && (xfer_tog_o !== xfer_ack_tog)) begin
      pend = 1'b1;
      ecnt = ECHO;
    end
  endtask

  task automatic wait_rdy(input int target, input int limit, input string tag);
    int n = 0;
    while (rdy_total < target && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_ready_reached"}, 64'(rdy_total >= target), 64'd1);
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done_reached"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    dest_rst = 1'b1;
    req_valid = '0;
    sticky    = '0;
    sb_q.delete();
    tick();
    tick();
    rst      = 1'b0;
    dest_rst = 1'b0;
    tick();
  endtask

  int base_rdy [NUM_REQ];
  int base_tog;
  int base_done;
  int base_total;
  int busy_low;

  initial begin
    rst          = 1'b1;
    dest_rst     = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    xfer_ack_tog = 1'b0;
    echo_en      = 1'b1;
    sticky       = '0;
    for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;

    repeat (3) tick();
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_tog", 64'(xfer_tog_o), 64'd0);
    check("rst_data", 64'(xfer_data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_done_id", 64'(done_id_o), 64'd0);
    check("rst_err", 64'(err_timeout_o), 64'd0);
    rst      = 1'b0;
    dest_rst = 1'b0;
    tick();

    // Single transfer from requester 0
    set_word(0, 32'hA5A5_0001);
    req_valid = 4'b0001;
    push(0);
    tick();
    check("t1_ready_latency", 64'(req_ready_o), 64'h1);
    check("t1_tog", 64'(xfer_tog_o), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd1);
    wait_done(1, 50, "t1");
    check("t1_done_id", 64'(done_id_o), 64'd0);
    check("t1_data_held", 64'(xfer_data_o), 64'hA5A5_0001);
    tick();
    check("t1_done_cleared", 64'(done_o), 64'd0);

    // All four requesters continuously valid for eight transfers
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      base_rdy[i] = rdy_cnt[i];
      set_word(i, 32'hC0DE_0000 + 32'(i));
    end
    base_tog  = tog_cnt;
    base_done = done_cnt;
    base_total = rdy_total;
    sticky    = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) push(k % NUM_REQ);
    wait_rdy(base_total + 8, 300, "t2");
    req_valid = '0;
    sticky    = '0;
    wait_done(base_done + 8, 50, "t2");
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("t2_ready_count_%0d", i), 64'(rdy_cnt[i] - base_rdy[i]), 64'd2);
    check("t2_tog_count", 64'(tog_cnt - base_tog), 64'd8);

    // Valids for 1 and 3 raised while requester 0 is waiting for its ack
    base_total = rdy_total;
    base_done  = done_cnt;
    set_word(0, 32'h1111_0000);
    req_valid = 4'b0001;
    push(0);
    wait_rdy(base_total + 1, 20, "t3a");
    set_word(1, 32'h2222_0001);
    set_word(3, 32'h3333_0003);
    req_valid = req_valid | 4'b1010;
    push(1);
    push(3);
    wait_rdy(base_total + 3, 100, "t3b");
    wait_done(base_done + 3, 50, "t3");

    // Reset two cycles after a launch to requester 1 (pointer would be 2)
    set_word(1, 32'h4444_0001);
    req_valid = 4'b0010;
    push(1);
    wait_rdy(rdy_total + 1, 20, "t4a");
    tick();
    rst      = 1'b1;
    dest_rst = 1'b1;
    req_valid = '0;
    sb_q.delete();
    tick();
    check("t4_tog", 64'(xfer_tog_o), 64'd0);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_ready", 64'(req_ready_o), 64'd0);
    check("t4_done", 64'(done_o), 64'd0);
    rst      = 1'b0;
    dest_rst = 1'b0;
    tick();
    base_done = done_cnt;
    set_word(0, 32'h5555_0000);
    set_word(2, 32'h5555_0002);
    req_valid = 4'b0101;
    push(0);
    push(2);
    wait_rdy(rdy_total + 2, 100, "t4b");
    wait_done(base_done + 2, 50, "t4");

`ifdef CDC_XFER_TIMEOUT_EN
    // No echo: timeout after the 16th WAIT_ACK cycle
    echo_en = 1'b0;
    set_word(1, 32'h6666_0001);
    req_valid = 4'b0010;
    push(1);
    wait_rdy(rdy_total + 1, 20, "t5a");
    repeat (TMO - 1) tick();
    check("t5_err_before", 64'(err_timeout_o), 64'd0);
    tick();
    check("t5_err_set", 64'(err_timeout_o), 64'd1);
    check("t5_busy_err", 64'(busy_o), 64'd1);
    base_total = rdy_total;
    req_valid = 4'b0100;
    repeat (20) tick();
    check("t5_no_grant_in_err", 64'(rdy_total), 64'(base_total));
    check("t5_err_sticky", 64'(err_timeout_o), 64'd1);
    apply_reset();
    check("t5_err_cleared", 64'(err_timeout_o), 64'd0);
    check("t5_busy_cleared", 64'(busy_o), 64'd0);
    echo_en = 1'b1;
`else
    // No echo: wait indefinitely, then a late echo completes the transfer
    echo_en = 1'b0;
    base_done = done_cnt;
    set_word(1, 32'h6666_0001);
    req_valid = 4'b0010;
    push(1);
    wait_rdy(rdy_total + 1, 20, "t6a");
    busy_low = 0;
    repeat (1000) begin
      tick();
      if (!busy_o) busy_low++;
    end
    check("t6_busy_held", 64'(busy_low), 64'd0);
    check("t6_err_zero", 64'(err_timeout_o), 64'd0);
    check("t6_no_done_yet", 64'(done_cnt), 64'(base_done));
    echo_en = 1'b1;
    wait_done(base_done + 1, 50, "t6");
    check("t6_done_id", 64'(done_id_o), 64'd1);
`endif

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
